helix_action_governor: RTL and testbench
========================================

// Module: helix_action_governor
// PURPOSE
//  Parametrised successor to the die-level precision stepper. Sits between Aperture action output and the external
//  action port: buffers actions in a DEPTH-entry FIFO and owns the NUM_MODES-way precision_mode fed to the Reactor.
//  Mode steps per delivered action, freezes under back-pressure (watermark hysteresis), optionally resets on large feedback.
// PARAMETERS
//  ACTION_W     `HELIX_ACTION_W    action word width
//  FEEDBACK_W   `HELIX_FEEDBACK_W  signed feedback delta width
//  DEPTH        4                  FIFO entries; power of 2, >=2
//  NUM_MODES    4                  precision modes; >=2, need not be power of 2
//  HI_WATER     3                  occupancy >= HI_WATER enters HOLD; 1..DEPTH
//  LO_WATER     1                  occupancy <= LO_WATER leaves HOLD; < HI_WATER
//  ADAPT_THRESH 64                 |feedback_delta| > this triggers mode reset (HELIX_ADAPT_EN only)
//  Derived: MODE_W=$clog2(NUM_MODES), CNT_W=$clog2(DEPTH+1)
// PORTS
//  clk             in   1           single clock, rising edge
//  rst_n           in   1           reset, synchronous, active-low
//  in_valid        in   1           action from Aperture valid
//  in_ready        out  1           FIFO can accept
//  in_data         in   ACTION_W    action payload
//  action_valid    out  1           action to world valid
//  action_ready    in   1           world accepts
//  action_data     out  ACTION_W    head-of-FIFO payload
//  feedback_valid  in   1           Loom feedback strobe (no ready; sampled when high)
//  feedback_delta  in   FEEDBACK_W  signed two's-complement delta
//  precision_mode  out  MODE_W      current precision mode to Reactor
//  occupancy       out  CNT_W       FIFO entries held, 0..DEPTH
//  hold            out  1           1 while state==HOLD
// BEHAVIOUR
//  Reset (rst_n==0 at clk edge): FIFO emptied, ptrs=0, occupancy=0, action_valid=0, in_ready=1, precision_mode=0,
//   state=RUN, hold=0. Mid-operation reset discards buffered actions; no output handshake on that edge.
//  Push = in_valid&&in_ready; pop = action_valid&&action_ready. in_ready = (occupancy!=DEPTH); action_valid = (occupancy!=0).
//  Latency: push at edge N -> action_valid at N+1 (no same-cycle bypass). action_data = mem[rd_ptr], held stable while
//   valid&&!ready. Simultaneous push+pop: occupancy unchanged; allowed at any non-full, non-empty level; full blocks push.
//  Pointers wrap modulo DEPTH (natural binary wrap).
//  FSM RUN/HOLD, evaluated on registered occupancy:
//   RUN -> HOLD when occupancy>=HI_WATER; HOLD -> RUN when occupancy<=LO_WATER; else stay.
//  Mode step: in RUN, each pop advances precision_mode by 1; NUM_MODES-1 wraps to 0. In HOLD, pops do not advance.
//   State transition and step use the same-edge values (step decision uses pre-edge state).
//  Throughput: one push and one pop per cycle max; FIFO never drops or duplicates.
// CONFIGURATION
//  HELIX_ADAPT_EN defined: on feedback_valid with |feedback_delta|>ADAPT_THRESH, precision_mode<=0 next edge,
//   overriding any same-cycle step, in both RUN and HOLD; state unaffected. Most-negative delta treated as magnitude
//   2^(FEEDBACK_W-1) (no overflow). Undefined: feedback ports present but ignored; mode driven by step rule only.
// STRUCTURE
//  helix_pkg: typedef enum logic {GOV_RUN, GOV_HOLD} helix_gov_state_e; default DEPTH/NUM_MODES/watermark constants.
//  Sub-module helix_sync_fifo (DEPTH, WIDTH; push/pop/occupancy); governor FSM + mode counter stay in this module.
// TESTING
//  1 Reset, then 1 push of 0xA5, ready=1 -> action_valid at +1 cycle, data 0xA5, mode 0->1 after pop, occupancy 0.
//  2 ready=0, push 5 words (DEPTH=4) -> in_ready=0 after 4th, 5th held off; drain gives 4 words in order, no loss.
//  3 Fill to 3 (HI_WATER) -> hold=1; pop 2 -> no mode change; occupancy 1 -> hold=0, next pop steps mode.
//  4 NUM_MODES=3, 7 pops in RUN -> mode sequence 1,2,0,1,2,0,1.
//  5 HELIX_ADAPT_EN, mode=2, feedback_delta=-100 valid with simultaneous pop -> mode=0; delta=+64 -> no reset.
//  6 Assert rst_n=0 for one edge with occupancy=3 -> occupancy=0, action_valid=0, mode=0, state RUN next cycle.

Source files
------------

// File: rtl/helix_pkg.sv
// Shared types and default constants for the Helix action governor.
// Width macros HELIX_ACTION_W / HELIX_FEEDBACK_W may be supplied by the build; defaults below.
`ifndef HELIX_ACTION_W
`define HELIX_ACTION_W 8
`endif
`ifndef HELIX_FEEDBACK_W
`define HELIX_FEEDBACK_W 16
`endif

package helix_pkg;

    localparam int unsigned HELIX_ACTION_W_DFLT   = `HELIX_ACTION_W;
    localparam int unsigned HELIX_FEEDBACK_W_DFLT = `HELIX_FEEDBACK_W;
    localparam int unsigned HELIX_DEPTH_DFLT      = 4;
    localparam int unsigned HELIX_NUM_MODES_DFLT  = 4;
    localparam int unsigned HELIX_HI_WATER_DFLT   = 3;
    localparam int unsigned HELIX_LO_WATER_DFLT   = 1;
    localparam int unsigned HELIX_ADAPT_THR_DFLT  = 64;

    typedef enum logic {
        GOV_RUN  = 1'b0,
        GOV_HOLD = 1'b1
    } helix_gov_state_e;

endpackage

// File: rtl/helix_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and occupancy count; no same-cycle bypass.
// Push is ignored when full and pop when empty, so callers may pass raw valid/ready terms.
module helix_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_not_full,
    output logic                       o_not_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_not_full;
    logic             r_not_empty;

    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_push = i_push && r_not_full;
    assign w_pop  = i_pop && r_not_empty;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    // Storage needs no reset: entries are only observable once counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_not_full  <= 1'b1;
            r_not_empty <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_cnt       <= w_cnt_nxt;
            r_not_full  <= (w_cnt_nxt != CNT_W'(DEPTH));
            r_not_empty <= (w_cnt_nxt != CNT_W'(0));
        end
    end

    assign o_data      = r_mem[r_rd_ptr];
    assign o_not_full  = r_not_full;
    assign o_not_empty = r_not_empty;
    assign o_occupancy = r_cnt;

endmodule

// File: rtl/helix_action_governor.sv
// Action FIFO plus precision-mode governor: mode steps per delivered action, frozen in HOLD.
// Optional feature HELIX_ADAPT_EN: large |feedback_delta| forces the mode back to 0.
module helix_action_governor
    import helix_pkg::*;
#(
    parameter int unsigned ACTION_W     = HELIX_ACTION_W_DFLT,
    parameter int unsigned FEEDBACK_W   = HELIX_FEEDBACK_W_DFLT,
    parameter int unsigned DEPTH        = HELIX_DEPTH_DFLT,
    parameter int unsigned NUM_MODES    = HELIX_NUM_MODES_DFLT,
    parameter int unsigned HI_WATER     = HELIX_HI_WATER_DFLT,
    parameter int unsigned LO_WATER     = HELIX_LO_WATER_DFLT,
    parameter int unsigned ADAPT_THRESH = HELIX_ADAPT_THR_DFLT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ACTION_W-1:0]            in_data,
    output logic                           action_valid,
    input  logic                           action_ready,
    output logic [ACTION_W-1:0]            action_data,
    input  logic                           feedback_valid,
    input  logic [FEEDBACK_W-1:0]          feedback_delta,
    output logic [$clog2(NUM_MODES)-1:0]   precision_mode,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy,
    output logic                           hold
);

    localparam int unsigned MODE_W = $clog2(NUM_MODES);
    localparam int unsigned CNT_W  = $clog2(DEPTH+1);

    helix_gov_state_e  r_state;
    helix_gov_state_e  w_state_nxt;
    logic [MODE_W-1:0] r_mode;
    logic [MODE_W-1:0] w_mode_nxt;
    logic              r_hold;
    logic              w_not_full;
    logic              w_not_empty;
    logic [CNT_W-1:0]  w_occ;
    logic              w_pop;
    logic              w_adapt;

    helix_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ACTION_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (in_valid),
        .i_data      (in_data),
        .i_pop       (action_ready),
        .o_data      (action_data),
        .o_not_full  (w_not_full),
        .o_not_empty (w_not_empty),
        .o_occupancy (w_occ)
    );

    assign w_pop = w_not_empty && action_ready;

`ifdef HELIX_ADAPT_EN
    // Sign-extend by one bit so the most-negative delta has a representable magnitude.
    logic [FEEDBACK_W:0] w_fb_ext;
    logic [FEEDBACK_W:0] w_fb_inv;
    logic [FEEDBACK_W:0] w_fb_mag;

    assign w_fb_ext = {feedback_delta[FEEDBACK_W-1], feedback_delta};
    assign w_fb_inv = ~w_fb_ext;
    assign w_fb_mag = feedback_delta[FEEDBACK_W-1] ? (w_fb_inv + (FEEDBACK_W+1)'(1)) : w_fb_ext;
    assign w_adapt  = feedback_valid && (w_fb_mag > (FEEDBACK_W+1)'(ADAPT_THRESH));
`else
    logic w_unused_fb;
    assign w_unused_fb = ^{feedback_valid, feedback_delta};
    assign w_adapt     = 1'b0;
`endif

    // Next state and next mode, both decided from pre-edge state and occupancy.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        case (r_state)
            GOV_RUN:  if (w_occ >= CNT_W'(HI_WATER)) w_state_nxt = GOV_HOLD;
            GOV_HOLD: if (w_occ <= CNT_W'(LO_WATER)) w_state_nxt = GOV_RUN;
            default:  w_state_nxt = GOV_RUN;
        endcase
        if ((r_state == GOV_RUN) && w_pop) begin
            w_mode_nxt = (r_mode == MODE_W'(NUM_MODES-1)) ? '0 : r_mode + MODE_W'(1);
        end
        if (w_adapt) begin
            w_mode_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= GOV_RUN;
            r_mode  <= '0;
            r_hold  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_hold  <= (w_state_nxt == GOV_HOLD);
        end
    end

    assign in_ready       = w_not_full;
    assign action_valid   = w_not_empty;
    assign occupancy      = w_occ;
    assign precision_mode = r_mode;
    assign hold           = r_hold;

endmodule

// File: tb/tb_helix_action_governor.sv
// Directed bench for helix_action_governor: default instance plus a NUM_MODES=3 instance.
module tb_helix_action_governor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        action_valid;
    logic        action_ready = 1'b0;
    logic [7:0]  action_data;
    logic        fb_valid = 1'b0;
    logic [15:0] fb_delta = '0;
    logic [1:0]  mode;
    logic [2:0]  occ;
    logic        hold;

    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic [7:0]  in_data3 = '0;
    logic        action_valid3;
    logic        action_ready3 = 1'b0;
    logic [7:0]  action_data3;
    logic        fb_valid3 = 1'b0;
    logic [15:0] fb_delta3 = '0;
    logic [1:0]  mode3;
    logic [2:0]  occ3;
    logic        hold3;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    helix_action_governor #(
        .ACTION_W(8), .FEEDBACK_W(16), .DEPTH(4), .NUM_MODES(4),
        .HI_WATER(3), .LO_WATER(1), .ADAPT_THRESH(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .action_valid(action_valid), .action_ready(action_ready), .action_data(action_data),
        .feedback_valid(fb_valid), .feedback_delta(fb_delta),
        .precision_mode(mode), .occupancy(occ), .hold(hold)
    );

    helix_action_governor #(
        .ACTION_W(8), .FEEDBACK_W(16), .DEPTH(4), .NUM_MODES(3),
        .HI_WATER(3), .LO_WATER(1), .ADAPT_THRESH(64)
    ) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .action_valid(action_valid3), .action_ready(action_ready3), .action_data(action_data3),
        .feedback_valid(fb_valid3), .feedback_delta(fb_delta3),
        .precision_mode(mode3), .occupancy(occ3), .hold(hold3)
    );

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++; if (occ !== 3'd0) begin errs++; $display("FAIL rst_occ got %0d exp 0", occ); end
        checks++; if (action_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b exp 0", action_valid); end
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %b exp 1", in_ready); end
        checks++; if (mode !== 2'd0) begin errs++; $display("FAIL rst_mode got %0d exp 0", mode); end
        checks++; if (hold !== 1'b0) begin errs++; $display("FAIL rst_hold got %b exp 0", hold); end
    endtask

    task automatic test_single();
        in_valid = 1'b1;
        in_data = 8'hA5;
        action_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (action_valid !== 1'b1) begin errs++; $display("FAIL t1_valid got %b exp 1", action_valid); end
        checks++; if (action_data !== 8'hA5) begin errs++; $display("FAIL t1_data got %h exp a5", action_data); end
        checks++; if (mode !== 2'd0) begin errs++; $display("FAIL t1_mode_pre got %0d exp 0", mode); end
        tick();
        action_ready = 1'b0;
        checks++; if (mode !== 2'd1) begin errs++; $display("FAIL t1_mode got %0d exp 1", mode); end
        checks++; if (occ !== 3'd0) begin errs++; $display("FAIL t1_occ got %0d exp 0", occ); end
        checks++; if (action_valid !== 1'b0) begin errs++; $display("FAIL t1_valid_end got %b exp 0", action_valid); end
    endtask

    task automatic test_fill_drain();
        action_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = 8'h10 + 8'(i);
            tick();
            if (i == 3) begin
                checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL t2_full_ready got %b exp 0", in_ready); end
                checks++; if (occ !== 3'd4) begin errs++; $display("FAIL t2_full_occ got %0d exp 4", occ); end
            end
        end
        in_valid = 1'b0;
        checks++; if (occ !== 3'd4) begin errs++; $display("FAIL t2_blocked_occ got %0d exp 4", occ); end
        checks++; if (hold !== 1'b1) begin errs++; $display("FAIL t2_hold got %b exp 1", hold); end
        action_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (action_valid !== 1'b1 || action_data !== 8'h10 + 8'(i)) begin
                errs++;
                $display("FAIL t2_drain%0d got v=%b d=%h exp v=1 d=%h", i, action_valid, action_data, 8'h10 + 8'(i));
            end
            tick();
        end
        action_ready = 1'b0;
        checks++; if (occ !== 3'd0) begin errs++; $display("FAIL t2_end_occ got %0d exp 0", occ); end
        checks++; if (mode !== 2'd1) begin errs++; $display("FAIL t2_mode got %0d exp 1", mode); end
        checks++; if (hold !== 1'b0) begin errs++; $display("FAIL t2_end_hold got %b exp 0", hold); end
    endtask

    task automatic test_hysteresis();
        action_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 8'h20 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        checks++; if (hold !== 1'b0) begin errs++; $display("FAIL t3_hold_lag got %b exp 0", hold); end
        tick();
        checks++; if (hold !== 1'b1) begin errs++; $display("FAIL t3_hold_on got %b exp 1", hold); end
        action_ready = 1'b1;
        tick();
        tick();
        action_ready = 1'b0;
        checks++; if (mode !== 2'd1) begin errs++; $display("FAIL t3_frozen_mode got %0d exp 1", mode); end
        checks++; if (occ !== 3'd1) begin errs++; $display("FAIL t3_occ got %0d exp 1", occ); end
        checks++; if (hold !== 1'b1) begin errs++; $display("FAIL t3_hold_kept got %b exp 1", hold); end
        tick();
        checks++; if (hold !== 1'b0) begin errs++; $display("FAIL t3_hold_off got %b exp 0", hold); end
        action_ready = 1'b1;
        tick();
        action_ready = 1'b0;
        checks++; if (mode !== 2'd2) begin errs++; $display("FAIL t3_step got %0d exp 2", mode); end
        checks++; if (occ !== 3'd0) begin errs++; $display("FAIL t3_end_occ got %0d exp 0", occ); end
    endtask

    task automatic test_mode_wrap3();
        logic [1:0] exp_m [7];
        exp_m = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        in_valid3 = 1'b1;
        action_ready3 = 1'b1;
        in_data3 = 8'h30;
        tick();
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (action_data3 !== 8'h30 + 8'(k)) begin
                errs++; $display("FAIL t4_data%0d got %h exp %h", k, action_data3, 8'h30 + 8'(k));
            end
            in_data3 = 8'h31 + 8'(k);
            tick();
            checks++;
            if (mode3 !== exp_m[k]) begin
                errs++; $display("FAIL t4_mode%0d got %0d exp %0d", k, mode3, exp_m[k]);
            end
        end
        in_valid3 = 1'b0;
        action_ready3 = 1'b0;
        checks++; if (occ3 !== 3'd1) begin errs++; $display("FAIL t4_occ got %0d exp 1", occ3); end
    endtask

    task automatic test_adapt();
        logic [1:0] exp_a;
        logic [1:0] exp_b;
`ifdef HELIX_ADAPT_EN
        exp_a = 2'd0;
        exp_b = 2'd1;
`else
        exp_a = 2'd3;
        exp_b = 2'd0;
`endif
        action_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h40;
        tick();
        in_data = 8'h41;
        tick();
        in_valid = 1'b0;
        checks++; if (mode !== 2'd2) begin errs++; $display("FAIL t5_mode_pre got %0d exp 2", mode); end
        action_ready = 1'b1;
        fb_valid = 1'b1;
        fb_delta = 16'hFF9C;
        tick();
        checks++; if (mode !== exp_a) begin errs++; $display("FAIL t5_neg100 got %0d exp %0d", mode, exp_a); end
        fb_delta = 16'd64;
        tick();
        checks++; if (mode !== exp_b) begin errs++; $display("FAIL t5_pos64 got %0d exp %0d", mode, exp_b); end
        action_ready = 1'b0;
        fb_delta = 16'h8000;
        tick();
        fb_valid = 1'b0;
        checks++; if (mode !== 2'd0) begin errs++; $display("FAIL t5_minneg got %0d exp 0", mode); end
        checks++; if (occ !== 3'd0) begin errs++; $display("FAIL t5_occ got %0d exp 0", occ); end
    endtask

    task automatic test_mid_reset();
        action_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h50;
        tick();
        in_valid = 1'b0;
        tick();
        action_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 8'h60 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (occ !== 3'd3 || hold !== 1'b1 || mode !== 2'd1) begin
            errs++; $display("FAIL t6_pre got occ=%0d hold=%b mode=%0d exp 3 1 1", occ, hold, mode);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (occ !== 3'd0) begin errs++; $display("FAIL t6_occ got %0d exp 0", occ); end
        checks++; if (action_valid !== 1'b0) begin errs++; $display("FAIL t6_valid got %b exp 0", action_valid); end
        checks++; if (mode !== 2'd0) begin errs++; $display("FAIL t6_mode got %0d exp 0", mode); end
        checks++; if (hold !== 1'b0) begin errs++; $display("FAIL t6_hold got %b exp 0", hold); end
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL t6_ready got %b exp 1", in_ready); end
        checks++; if (occ3 !== 3'd0) begin errs++; $display("FAIL t6_occ3 got %0d exp 0", occ3); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_hysteresis();
        test_mode_wrap3();
        test_adapt();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
